tile_console_writer: RTL and testbench
======================================

Name: tile_console_writer

Overview:
Upstream feeder for the tile renderer. Accepts a byte stream of characters and control codes, and writes the results into the shared tile RAM using the renderer's layout:
- Page table: 2-byte little-endian row_base at {PAGE_BASE, row, 3'bxxx}.
- Character byte at row_base+col; attribute byte at row_base+col+32.

The block keeps a cursor and scrolls by rewriting page-table pointers rather than moving cell data. It writes only in cycles where the top level grants the RAM port (typically vblank/hblank).

Parameters:
- PAGE_BASE, 8'h00, page-table base (high address byte).
- DATA_BASE, 16'h0100, address of physical row 0 cell storage.
- ROWS, 30, visible text rows (2..32).
- ATTR_DEFAULT, 8'h0F, attribute used when clearing cells.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  character or control code.
- in_attr  in  8  attribute for a printable character.
- in_valid  in  1  in_data/in_attr valid.
- in_ready  out  1  block accepts a byte this cycle.
- wr_grant  in  1  RAM port owned by this block this cycle.
- wr_addr  out  16  RAM write address (registered).
- wr_data  out  8  RAM write data (registered).
- wr_en  out  1  write strobe = pending & wr_grant.
- busy  out  1  high in any state other than IDLE.
- cur_row  out  5  cursor display row.
- cur_col  out  5  cursor column.

Behaviour:
- Reset (async, reset=0):
  - FSM enters INIT_PT.
  - wr_en=0, wr_addr=0, wr_data=0, in_ready=0, busy=1, cur_row=0, cur_col=0, top=0.
  - Reset asserted mid-operation aborts everything; wr_en falls in the same cycle.
- States: INIT_PT, INIT_CLR, IDLE, WR_CHAR, WR_ATTR, SCROLL_PT, SCROLL_CLR.
- Write rule:
  - Every non-IDLE state holds a pending write in wr_addr/wr_data.
  - The write commits, and the sequencer advances, only in cycles with wr_grant=1.
  - With wr_grant=0, everything holds and wr_en=0.
- Page-table entry r (r=0..ROWS-1):
  - Bytes at {PAGE_BASE, r[4:0], 3'b000} (low byte) and {..., 3'b001} (high byte).
  - Value = DATA_BASE + ((top+r) mod ROWS)*64, truncated to 16 bits.
- INIT_PT: writes 2*ROWS page-table bytes, r ascending, low byte then high byte.
- INIT_CLR: for phys 0..ROWS-1, writes offsets 0..31 with 8'h20, then offsets 32..63 with ATTR_DEFAULT. Then goes to IDLE.
- IDLE: in_ready=1; a byte is accepted when in_valid&in_ready.
  - 8'h0D: cur_col=0.
  - 8'h08: cur_col-1 if >0, else no change.
  - 8'h0A: cur_col=0 and the row advances.
  - 8'h0C: top=0, cursor=(0,0), go to INIT_PT.
  - Control codes take effect in the acceptance cycle; in_ready stays high, except for 8'h0C and for a row advance that scrolls.
  - Any other byte goes to WR_CHAR.
- WR_CHAR then WR_ATTR:
  - Address = DATA_BASE + ((top+cur_row) mod ROWS)*64 + cur_col.
  - Attribute address adds 32.
  - Afterwards cur_col+1; on col 31 → col 0 and the row advances.
  - Returns to IDLE, so in_ready is high again the cycle after the attribute commit.
- Row advance:
  - If cur_row < ROWS-1: cur_row+1.
  - Otherwise: top=(top+1) mod ROWS, cur_row stays ROWS-1, go to SCROLL_PT.
- SCROLL_PT: identical to INIT_PT using the new top.
- SCROLL_CLR: clears phys row (top+ROWS-1) mod ROWS (64 writes, same pattern as INIT_CLR), then goes to IDLE.
- Costs with ROWS=30 and continuous grant:
  - Init 60+1920 = 1980 grant cycles.
  - Scroll 124.
  - Printable character 2.
- Arithmetic: top is 5 bits with explicit mod ROWS compare-subtract (no divider); all addresses wrap at 16 bits.

Decomposition:
- Package tile_console_pkg holds: COLS=32, ROW_STRIDE=64, ATTR_OFS=32, the control-code constants, and the state enum.
- Sub-module tile_addr_gen (combinational) maps (top, display row, byte offset) to a physical cell address and page-table entry value. It is shared by the write and scroll paths.

Test Plan:
- Reset released, grant=1:
  - First writes are 0x0000←0x00, 0x0001←0x01, 0x0008←0x40, 0x0009←0x01.
  - Then 0x0100←0x20 … 0x0120←0x0F.
  - busy falls after exactly 1980 wr_en pulses.
- Char 0x41, attr 0x1F at (0,0) → 0x0100←0x41, then 0x0120←0x1F; cur_col=1; in_ready high on the next cycle.
- Grant stall: wr_grant=0 for 10 cycles between the char and attribute writes → wr_en=0 and wr_addr held at 0x0120 throughout; the write completes on the first granted cycle.
- 32 printable bytes from (0,0), then a 33rd → 33rd char written at 0x0140; cursor (1,1).
- Cursor at row 29, send 0x0A:
  - Page-table row0 ← 0x0140 and row29 ← 0x0100.
  - Then 0x0100..0x013F cleared.
  - Cursor (29,0).
- Backspace at col 0 → no change. Reset pulled low mid-SCROLL_CLR → wr_en=0 immediately; after release the init sequence restarts at 0x0000.

Source files
------------

// File: rtl/tile_console_pkg.sv
// Shared constants, control codes and sequencer states for the tile console writer.
package tile_console_pkg;

  localparam int COLS       = 32;  // character cells per text row
  localparam int ROW_STRIDE = 64;  // bytes per physical row (chars + attributes)
  localparam int ATTR_OFS   = 32;  // attribute bytes follow the character bytes

  localparam logic [7:0] CC_BS      = 8'h08;  // backspace
  localparam logic [7:0] CC_LF      = 8'h0A;  // line feed
  localparam logic [7:0] CC_FF      = 8'h0C;  // form feed: full re-init
  localparam logic [7:0] CC_CR      = 8'h0D;  // carriage return
  localparam logic [7:0] CHAR_BLANK = 8'h20;  // character written when clearing

  typedef enum logic [2:0] {
    ST_INIT_PT    = 3'd0,
    ST_INIT_CLR   = 3'd1,
    ST_IDLE       = 3'd2,
    ST_WR_CHAR    = 3'd3,
    ST_WR_ATTR    = 3'd4,
    ST_SCROLL_PT  = 3'd5,
    ST_SCROLL_CLR = 3'd6
  } state_e;

  // Increment a 5-bit row-style index, wrapping to zero after 'last'.
  function automatic logic [4:0] wrap_inc5(input logic [4:0] v, input logic [4:0] last);
    logic [4:0] r;
    if (v == last) begin
      r = 5'd0;
    end else begin
      r = v + 5'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tile_console_writer_addr_gen.sv
// Maps (top, display row, byte offset) to the physical row base and cell address.
// The display-to-physical row rotation uses one compare-subtract, which is enough
// because both top and row are always below ROWS.
module tile_addr_gen #(
  parameter logic [15:0] DATA_BASE = 16'h0100,
  parameter int          ROWS      = 30
) (
  input  logic [4:0]  top_i,
  input  logic [4:0]  row_i,
  input  logic [5:0]  off_i,
  output logic [15:0] row_base_o,
  output logic [15:0] cell_addr_o
);
  import tile_console_pkg::*;

  logic [5:0] sum_s;
  logic [4:0] phys_s;

  // Rotate display row by top modulo ROWS, then scale into the cell storage area.
  always_comb begin
    sum_s = {1'b0, top_i} + {1'b0, row_i};
    if (sum_s >= 6'(ROWS)) begin
      phys_s = 5'(sum_s - 6'(ROWS));
    end else begin
      phys_s = sum_s[4:0];
    end
    row_base_o  = DATA_BASE + (16'(phys_s) * 16'(ROW_STRIDE));
    cell_addr_o = row_base_o + {10'd0, off_i};
  end

endmodule

// File: rtl/tile_console_writer.sv
// Byte-stream console feeding the tile renderer's RAM. Keeps a cursor, writes
// characters/attributes, and scrolls by rewriting the page table and clearing
// the newly exposed physical row. RAM writes happen only when wr_grant is high.
module tile_console_writer #(
  parameter logic [7:0]  PAGE_BASE    = 8'h00,
  parameter logic [15:0] DATA_BASE    = 16'h0100,
  parameter int          ROWS         = 30,
  parameter logic [7:0]  ATTR_DEFAULT = 8'h0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic [7:0]  in_attr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        wr_grant,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic [4:0]  cur_row,
  output logic [4:0]  cur_col
);
  import tile_console_pkg::*;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [5:0] LAST_OFS = 6'(ROW_STRIDE - 1);

  state_e      state_q, state_d;
  logic [4:0]  top_q, top_d;
  logic [4:0]  cur_row_q, cur_row_d;
  logic [4:0]  cur_col_q, cur_col_d;
  logic [4:0]  seq_row_q, seq_row_d;   // page-table row or physical row being cleared
  logic [5:0]  seq_off_q, seq_off_d;   // byte select (bit 0) or cell offset
  logic [7:0]  char_q, char_d;
  logic [7:0]  attr_q, attr_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        run_q;                  // low for the first cycle out of reset

  logic        commit_s;
  logic        accept_s;
  logic        at_bottom_s;
  logic [4:0]  top_inc_s;
  logic [4:0]  ag_top_s, ag_row_s;
  logic [5:0]  ag_off_s;
  logic [15:0] ag_base_s, ag_cell_s;

  tile_addr_gen #(
    .DATA_BASE (DATA_BASE),
    .ROWS      (ROWS)
  ) u_addr_gen (
    .top_i       (ag_top_s),
    .row_i       (ag_row_s),
    .off_i       (ag_off_s),
    .row_base_o  (ag_base_s),
    .cell_addr_o (ag_cell_s)
  );

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign commit_s    = run_q & (state_q != ST_IDLE) & wr_grant;
  assign wr_en       = commit_s;
  assign accept_s    = in_valid & in_ready;
  assign at_bottom_s = (cur_row_q == LAST_ROW);
  assign top_inc_s   = wrap_inc5(top_q, LAST_ROW);
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign cur_row     = cur_row_q;
  assign cur_col     = cur_col_q;

  // Sequencer next state, cursor/top updates and per-state counters.
  always_comb begin
    state_d   = state_q;
    top_d     = top_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    seq_row_d = seq_row_q;
    seq_off_d = seq_off_q;
    char_d    = char_q;
    attr_d    = attr_q;
    case (state_q)
      ST_INIT_PT, ST_SCROLL_PT: begin
        if (commit_s) begin
          if (seq_off_q[0] == 1'b0) begin
            seq_off_d = 6'd1;
          end else if (seq_row_q == LAST_ROW) begin
            state_d   = (state_q == ST_INIT_PT) ? ST_INIT_CLR : ST_SCROLL_CLR;
            seq_row_d = 5'd0;
            seq_off_d = 6'd0;
          end else begin
            seq_row_d = seq_row_q + 5'd1;
            seq_off_d = 6'd0;
          end
        end else begin
          seq_off_d = seq_off_q;
        end
      end
      ST_INIT_CLR: begin
        if (commit_s) begin
          if (seq_off_q != LAST_OFS) begin
            seq_off_d = seq_off_q + 6'd1;
          end else if (seq_row_q == LAST_ROW) begin
            state_d = ST_IDLE;
          end else begin
            seq_row_d = seq_row_q + 5'd1;
            seq_off_d = 6'd0;
          end
        end else begin
          seq_off_d = seq_off_q;
        end
      end
      ST_SCROLL_CLR: begin
        if (commit_s) begin
          if (seq_off_q == LAST_OFS) begin
            state_d = ST_IDLE;
          end else begin
            seq_off_d = seq_off_q + 6'd1;
          end
        end else begin
          seq_off_d = seq_off_q;
        end
      end
      ST_IDLE: begin
        if (accept_s) begin
          case (in_data)
            CC_CR: cur_col_d = 5'd0;
            CC_BS: begin
              if (cur_col_q != 5'd0) begin
                cur_col_d = cur_col_q - 5'd1;
              end else begin
                cur_col_d = cur_col_q;
              end
            end
            CC_LF: begin
              cur_col_d = 5'd0;
              if (at_bottom_s) begin
                top_d     = top_inc_s;
                state_d   = ST_SCROLL_PT;
                seq_row_d = 5'd0;
                seq_off_d = 6'd0;
              end else begin
                cur_row_d = cur_row_q + 5'd1;
              end
            end
            CC_FF: begin
              top_d     = 5'd0;
              cur_row_d = 5'd0;
              cur_col_d = 5'd0;
              seq_row_d = 5'd0;
              seq_off_d = 6'd0;
              state_d   = ST_INIT_PT;
            end
            default: begin
              char_d  = in_data;
              attr_d  = in_attr;
              state_d = ST_WR_CHAR;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_CHAR: begin
        if (commit_s) begin
          state_d = ST_WR_ATTR;
        end else begin
          state_d = ST_WR_CHAR;
        end
      end
      ST_WR_ATTR: begin
        if (commit_s) begin
          state_d = ST_IDLE;
          if (cur_col_q != LAST_COL) begin
            cur_col_d = cur_col_q + 5'd1;
          end else begin
            cur_col_d = 5'd0;
            if (at_bottom_s) begin
              top_d     = top_inc_s;
              state_d   = ST_SCROLL_PT;
              seq_row_d = 5'd0;
              seq_off_d = 6'd0;
            end else begin
              cur_row_d = cur_row_q + 5'd1;
            end
          end
        end else begin
          state_d = ST_WR_ATTR;
        end
      end
      default: state_d = ST_INIT_PT;
    endcase
  end

  // Pending write for the state being entered, so it is registered and stable on arrival.
  always_comb begin
    ag_top_s  = top_d;
    ag_row_s  = cur_row_d;
    ag_off_s  = {1'b0, cur_col_d};
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_d)
      ST_INIT_PT, ST_SCROLL_PT: begin
        ag_row_s  = seq_row_d;
        ag_off_s  = 6'd0;
        wr_addr_d = {PAGE_BASE, seq_row_d, 2'b00, seq_off_d[0]};
        wr_data_d = seq_off_d[0] ? ag_base_s[15:8] : ag_base_s[7:0];
      end
      ST_INIT_CLR: begin
        ag_top_s  = 5'd0;
        ag_row_s  = seq_row_d;
        ag_off_s  = seq_off_d;
        wr_addr_d = ag_cell_s;
        wr_data_d = seq_off_d[5] ? ATTR_DEFAULT : CHAR_BLANK;
      end
      ST_SCROLL_CLR: begin
        ag_row_s  = LAST_ROW;
        ag_off_s  = seq_off_d;
        wr_addr_d = ag_cell_s;
        wr_data_d = seq_off_d[5] ? ATTR_DEFAULT : CHAR_BLANK;
      end
      ST_WR_CHAR: begin
        wr_addr_d = ag_cell_s;
        wr_data_d = char_d;
      end
      ST_WR_ATTR: begin
        ag_off_s  = 6'(ATTR_OFS) + {1'b0, cur_col_d};
        wr_addr_d = ag_cell_s;
        wr_data_d = attr_d;
      end
      default: begin
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
      end
    endcase
  end

  // State, cursor and pending-write registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT_PT;
      top_q     <= 5'd0;
      cur_row_q <= 5'd0;
      cur_col_q <= 5'd0;
      seq_row_q <= 5'd0;
      seq_off_q <= 6'd0;
      char_q    <= 8'h00;
      attr_q    <= 8'h00;
      wr_addr_q <= 16'h0000;
      wr_data_q <= 8'h00;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      top_q     <= top_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      seq_row_q <= seq_row_d;
      seq_off_q <= seq_off_d;
      char_q    <= char_d;
      attr_q    <= attr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      run_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tile_console_writer.sv
// Directed bench for tile_console_writer: init sequence, character writes,
// grant stalls, wrap, scroll and mid-operation reset.
module tb_tile_console_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data, in_attr;
  logic        in_valid, in_ready, wr_grant, wr_en, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  cur_row, cur_col;

  int checks   = 0;
  int failures = 0;

  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];

  typedef struct {
    logic [7:0] d;
    logic [7:0] a;
    int         nw;    // RAM writes produced
    int         addr;  // character address when nw==2
    int         row;
    int         col;
  } vec_t;
  vec_t vt[9];

  tile_console_writer dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_attr  (in_attr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_grant (wr_grant),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .cur_row  (cur_row),
    .cur_col  (cur_col)
  );

  always #5 clk = ~clk;

  // Record every RAM write strobe.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input int ea, input int ed);
    checks++;
    if (idx >= log_addr.size()) begin
      failures++;
      $display("FAIL %s: write %0d missing (only %0d writes)", name, idx, log_addr.size());
    end else if (int'(log_addr[idx]) != ea || int'(log_data[idx]) != ed) begin
      failures++;
      $display("FAIL %s: actual=0x%04h<-0x%02h required=0x%04h<-0x%02h",
               name, log_addr[idx], log_data[idx], ea, ed);
    end
  endtask

  function automatic int pt_val(input int top, input int r);
    return 16'h0100 + ((top + r) % 30) * 64;
  endfunction

  // Compare the page-table rewrite plus nclr row clears starting at log index base.
  task automatic check_seq(input string name, input int base, input int top,
                           input int phys0, input int nclr);
    int n;
    int bad;
    int ea;
    int ed;
    n   = 60 + nclr * 64;
    bad = 0;
    chk({name, "_len"}, log_addr.size() - base, n);
    for (int k = 0; k < n; k++) begin
      if (k < 60) begin
        ea = (k / 2) * 8 + (k % 2);
        ed = (k % 2 == 1) ? (pt_val(top, k / 2) >> 8) : (pt_val(top, k / 2) & 255);
      end else begin
        ea = 16'h0100 + ((phys0 + (k - 60) / 64) % 30) * 64 + ((k - 60) % 64);
        ed = (((k - 60) % 64) < 32) ? 8'h20 : 8'h0F;
      end
      if (base + k >= log_addr.size()) begin
        bad++;
      end else if (int'(log_addr[base + k]) != ea || int'(log_data[base + k]) != ed) begin
        bad++;
      end
    end
    chk({name, "_seq_bad"}, bad, 0);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int i;
    i = 0;
    @(negedge clk);
    while (busy && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a);
    int i;
    i = 0;
    @(negedge clk);
    while (!in_ready && i < 5000) begin
      @(negedge clk);
      i++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_ready: in_ready=0 after %0d cycles, required 1", i);
    end
    in_data  = d;
    in_attr  = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    int base;
    int bad;
    int i;

    vt[0] = '{8'h42, 8'h07, 2, 16'h0101, 0, 2};
    vt[1] = '{8'h0D, 8'h00, 0, 0, 0, 0};
    vt[2] = '{8'h08, 8'h00, 0, 0, 0, 0};
    vt[3] = '{8'h43, 8'h02, 2, 16'h0100, 0, 1};
    vt[4] = '{8'h08, 8'h00, 0, 0, 0, 0};
    vt[5] = '{8'h0A, 8'h00, 0, 0, 1, 0};
    vt[6] = '{8'h44, 8'h33, 2, 16'h0140, 1, 1};
    vt[7] = '{8'h0D, 8'h00, 0, 0, 1, 0};
    vt[8] = '{8'h08, 8'h00, 0, 0, 1, 0};

    reset    = 1'b0;
    wr_grant = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_attr  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_cur_row", cur_row, 0);
    chk("rst_cur_col", cur_col, 0);

    // Power-up init.
    reset = 1'b1;
    wait_idle("init", 3000);
    chk_log("init_w0", 0, 16'h0000, 8'h00);
    chk_log("init_w1", 1, 16'h0001, 8'h01);
    chk_log("init_w2", 2, 16'h0008, 8'h40);
    chk_log("init_w3", 3, 16'h0009, 8'h01);
    chk_log("init_clr_first", 60, 16'h0100, 8'h20);
    chk_log("init_attr_first", 92, 16'h0120, 8'h0F);
    check_seq("init", 0, 0, 0, 30);

    // Printable char with a grant stall before the attribute write.
    base = log_addr.size();
    send(8'h41, 8'h1F);
    @(negedge clk);
    chk("char_wr_en", wr_en, 1);
    chk("char_addr", wr_addr, 16'h0100);
    chk("char_data", wr_data, 8'h41);
    @(posedge clk);
    #1 wr_grant = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || wr_addr !== 16'h0120) bad++;
    end
    chk("stall_hold_bad", bad, 0);
    wr_grant = 1'b1;
    #1;
    chk("stall_resume_wr_en", wr_en, 1);
    chk("stall_resume_addr", wr_addr, 16'h0120);
    chk("stall_resume_data", wr_data, 8'h1F);
    @(posedge clk);
    @(negedge clk);
    chk("char_in_ready_next", in_ready, 1);
    chk("char_cur_col", cur_col, 1);
    chk("char_nwrites", log_addr.size() - base, 2);

    // Table of characters and control codes.
    for (int v = 0; v < 9; v++) begin
      base = log_addr.size();
      send(vt[v].d, vt[v].a);
      wait_idle($sformatf("vec%0d", v), 100);
      chk($sformatf("vec%0d_row", v), cur_row, vt[v].row);
      chk($sformatf("vec%0d_col", v), cur_col, vt[v].col);
      chk($sformatf("vec%0d_nw", v), log_addr.size() - base, vt[v].nw);
      if (vt[v].nw == 2) begin
        chk_log($sformatf("vec%0d_char", v), base, vt[v].addr, vt[v].d);
        chk_log($sformatf("vec%0d_attr", v), base + 1, vt[v].addr + 32, vt[v].a);
      end
    end

    // Form feed: full re-init, cursor home.
    base = log_addr.size();
    send(8'h0C, 8'h00);
    @(negedge clk);
    chk("ff_in_ready", in_ready, 0);
    chk("ff_row", cur_row, 0);
    chk("ff_col", cur_col, 0);
    wait_idle("ff", 3000);
    check_seq("ff", base, 0, 0, 30);

    // 32 characters fill row 0, the 33rd wraps to row 1.
    for (int c = 0; c < 32; c++) send(8'h50 + 8'(c), 8'h07);
    send(8'h7A, 8'h1E);
    wait_idle("wrap", 100);
    i = log_addr.size();
    chk_log("wrap_col31", i - 4, 16'h011F, 8'h6F);
    chk_log("wrap_char33", i - 2, 16'h0140, 8'h7A);
    chk_log("wrap_attr33", i - 1, 16'h0160, 8'h1E);
    chk("wrap_row", cur_row, 1);
    chk("wrap_col", cur_col, 1);

    // Walk to the bottom row, then line feed scrolls.
    send(8'h0D, 8'h00);
    for (int l = 0; l < 28; l++) send(8'h0A, 8'h00);
    @(negedge clk);
    chk("bottom_row", cur_row, 29);
    chk("bottom_busy", busy, 0);
    base = log_addr.size();
    send(8'h0A, 8'h00);
    @(negedge clk);
    chk("scroll_in_ready", in_ready, 0);
    wait_idle("scroll", 300);
    chk_log("scroll_pt0_lo", base, 16'h0000, 8'h40);
    chk_log("scroll_pt0_hi", base + 1, 16'h0001, 8'h01);
    chk_log("scroll_pt29_lo", base + 58, 16'h00E8, 8'h00);
    chk_log("scroll_pt29_hi", base + 59, 16'h00E9, 8'h01);
    check_seq("scroll", base, 1, 0, 1);
    chk("scroll_row", cur_row, 29);
    chk("scroll_col", cur_col, 0);

    // Second scroll, aborted by reset in the clear phase.
    base = log_addr.size();
    send(8'h0A, 8'h00);
    i = 0;
    while (log_addr.size() < base + 70 && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("abort_reached_clr", (log_addr.size() >= base + 70) ? 1 : 0, 1);
    reset = 1'b0;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 1);
    chk("abort_row", cur_row, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base = log_addr.size();
    wait_idle("reinit", 3000);
    chk_log("reinit_w0", base, 16'h0000, 8'h00);
    check_seq("reinit", base, 0, 0, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
